// File: rtl/ahb_slave_bridge_if.sv
// rtl/ahb_slave_bridge_if.sv - AHB-Lite slave side and backend request/response signal bundle
interface ahb_slave_bridge_if #(
  parameter int AHB_DATA_WIDTH = 32,
  parameter int AHB_ADDR_WIDTH = 32
);
  logic                        ahb_sel_in;
  logic [AHB_ADDR_WIDTH-1:0]   ahb_addr_in;
  logic [1:0]                  ahb_trans_in;
  logic [2:0]                  ahb_burst_in;
  logic [2:0]                  ahb_size_in;
  logic                        ahb_write_in;
  logic [AHB_DATA_WIDTH-1:0]   ahb_wdata_in;
  logic                        ahb_ready_in;
  logic                        ahb_readyout_out;
  logic                        ahb_resp_out;
  logic [AHB_DATA_WIDTH-1:0]   ahb_rdata_out;
  logic                        other_req_out;
  logic [AHB_ADDR_WIDTH-1:0]   other_addr_out;
  logic                        other_write_out;
  logic [2:0]                  other_size_out;
  logic [AHB_DATA_WIDTH/8-1:0] other_strb_out;
  logic [AHB_DATA_WIDTH-1:0]   other_wdata_out;
  logic                        other_ready_in;
  logic                        other_error_in;
  logic [AHB_DATA_WIDTH-1:0]   other_rdata_in;

  modport slave (
    input  ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_burst_in, ahb_size_in,
           ahb_write_in, ahb_wdata_in, ahb_ready_in,
           other_ready_in, other_error_in, other_rdata_in,
    output ahb_readyout_out, ahb_resp_out, ahb_rdata_out,
           other_req_out, other_addr_out, other_write_out, other_size_out,
           other_strb_out, other_wdata_out
  );

  modport master (
    output ahb_sel_in, ahb_addr_in, ahb_trans_in, ahb_burst_in, ahb_size_in,
           ahb_write_in, ahb_wdata_in, ahb_ready_in,
           other_ready_in, other_error_in, other_rdata_in,
    input  ahb_readyout_out, ahb_resp_out, ahb_rdata_out,
           other_req_out, other_addr_out, other_write_out, other_size_out,
           other_strb_out, other_wdata_out
  );
endinterface

// File: rtl/ahb_slave_bridge.sv
// rtl/ahb_slave_bridge.sv - AHB-Lite slave to single-outstanding backend bridge; optional wait timeout under AHB_TIMEOUT_EN
module ahb_slave_bridge #(
  parameter int AHB_DATA_WIDTH   = 32,
  parameter int AHB_ADDR_WIDTH   = 32,
  parameter int AHB_WAIT_TIMEOUT = 6
) (
  input logic               ahb_clk_in,
  input logic               ahb_rst_in,
  ahb_slave_bridge_if.slave bus
);
  localparam int NB = AHB_DATA_WIDTH / 8;
  localparam int LB = $clog2(NB);
  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_ERR1, ST_ERR2} state_t;

  state_t                    state, state_nxt, addr_phase_nxt;
  logic                      req_q, write_q, trk_active, trk_inf, burst_write_q;
  logic [AHB_ADDR_WIDTH-1:0] addr_q, pred_addr;
  logic [2:0]                size_q, burst_q, burst_size_q;
  logic [NB-1:0]             strb_q, strb_nxt;
  logic [3:0]                beats_left;
  logic                      readyout, accept, active_acc, seq_room;
  logic                      size_ok, align_ok, seq_ok, legal;

`ifdef AHB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(AHB_WAIT_TIMEOUT);
  logic [WAIT_W-1:0] wait_cnt;
  logic              timed_out;
  assign timed_out = (wait_cnt == WAIT_W'(AHB_WAIT_TIMEOUT - 1));
`endif

  // Address of the beat following a, honouring the wrap boundary of WRAPn bursts
  function automatic logic [AHB_ADDR_WIDTH-1:0] next_addr(
    input logic [AHB_ADDR_WIDTH-1:0] a, input logic [2:0] b, input logic [2:0] s);
    logic [AHB_ADDR_WIDTH-1:0] step, wrap_mask;
    step = AHB_ADDR_WIDTH'(32'd1 << s);
    case (b)
      3'd2:    wrap_mask = AHB_ADDR_WIDTH'((32'd4 << s) - 32'd1);
      3'd4:    wrap_mask = AHB_ADDR_WIDTH'((32'd8 << s) - 32'd1);
      3'd6:    wrap_mask = AHB_ADDR_WIDTH'((32'd16 << s) - 32'd1);
      default: wrap_mask = '1;
    endcase
    return (a & ~wrap_mask) | ((a + step) & wrap_mask);
  endfunction

  // Remaining SEQ beats after the NONSEQ of a fixed-length burst
  function automatic logic [3:0] beats_for(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

  assign readyout   = (state == ST_ACCESS) ? ((bus.other_ready_in || bus.other_error_in) && !bus.other_error_in)
                                           : (state != ST_ERR1);
  assign accept     = bus.ahb_sel_in && bus.ahb_ready_in && readyout;
  assign active_acc = accept && bus.ahb_trans_in[1];
  assign seq_room   = trk_active && (trk_inf || (beats_left != 4'd0));
  assign size_ok    = (32'd8 << bus.ahb_size_in) <= 32'(AHB_DATA_WIDTH);
  assign align_ok   = (bus.ahb_addr_in & AHB_ADDR_WIDTH'((32'd1 << bus.ahb_size_in) - 32'd1)) == '0;
  assign seq_ok     = seq_room && (bus.ahb_addr_in == pred_addr) && (bus.ahb_burst_in == burst_q) &&
                      (bus.ahb_size_in == burst_size_q) && (bus.ahb_write_in == burst_write_q);
  assign legal      = size_ok && align_ok && ((bus.ahb_trans_in == TR_NONSEQ) || seq_ok);
  assign strb_nxt   = NB'(((32'd1 << (32'd1 << bus.ahb_size_in)) - 32'd1) << bus.ahb_addr_in[LB-1:0]);

  // Next-state decode; an accepted address phase decides between ACCESS, ERR1 and IDLE
  always_comb begin
    addr_phase_nxt = ST_IDLE;
    if (active_acc) addr_phase_nxt = legal ? ST_ACCESS : ST_ERR1;
    state_nxt = state;
    case (state)
      ST_IDLE, ST_ERR2: state_nxt = addr_phase_nxt;
      ST_ERR1:          state_nxt = ST_ERR2;
      ST_ACCESS: begin
        if (bus.other_error_in)      state_nxt = ST_ERR1;
        else if (bus.other_ready_in) state_nxt = addr_phase_nxt;
`ifdef AHB_TIMEOUT_EN
        else if (timed_out)          state_nxt = ST_ERR1;
`endif
      end
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // FSM, registered backend request fields and burst tracking
  always_ff @(posedge ahb_clk_in) begin
    if (ahb_rst_in) begin
      state         <= ST_IDLE;
      req_q         <= 1'b0;
      addr_q        <= '0;
      write_q       <= 1'b0;
      size_q        <= 3'd0;
      strb_q        <= '0;
      trk_active    <= 1'b0;
      trk_inf       <= 1'b0;
      beats_left    <= 4'd0;
      pred_addr     <= '0;
      burst_q       <= 3'd0;
      burst_size_q  <= 3'd0;
      burst_write_q <= 1'b0;
`ifdef AHB_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      state <= state_nxt;
      req_q <= (state_nxt == ST_ACCESS);
      if (active_acc && legal) begin
        addr_q  <= bus.ahb_addr_in;
        write_q <= bus.ahb_write_in;
        size_q  <= bus.ahb_size_in;
        strb_q  <= strb_nxt;
      end
`ifdef AHB_TIMEOUT_EN
      if (state == ST_ACCESS && state_nxt == ST_ACCESS && !bus.other_ready_in && !bus.other_error_in)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
`endif
      if (accept) begin
        case (bus.ahb_trans_in)
          TR_NONSEQ: begin
            trk_active <= legal;
            if (legal) begin
              trk_inf       <= (bus.ahb_burst_in == 3'd1);
              beats_left    <= beats_for(bus.ahb_burst_in);
              burst_q       <= bus.ahb_burst_in;
              burst_size_q  <= bus.ahb_size_in;
              burst_write_q <= bus.ahb_write_in;
              pred_addr     <= next_addr(bus.ahb_addr_in, bus.ahb_burst_in, bus.ahb_size_in);
            end
          end
          TR_SEQ: begin
            // Illegal SEQ beats still consume a slot so the burst stays in step
            if (seq_room) begin
              if (!trk_inf) beats_left <= beats_left - 4'd1;
              pred_addr <= next_addr(pred_addr, burst_q, burst_size_q);
            end
          end
          TR_IDLE: trk_active <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  assign bus.ahb_readyout_out = readyout;
  assign bus.ahb_resp_out     = (state == ST_ERR1) || (state == ST_ERR2);
  assign bus.ahb_rdata_out    = (state == ST_ACCESS && bus.other_ready_in) ? bus.other_rdata_in : '0;
  assign bus.other_req_out    = req_q;
  assign bus.other_addr_out   = addr_q;
  assign bus.other_write_out  = write_q;
  assign bus.other_size_out   = size_q;
  assign bus.other_strb_out   = strb_q;
  assign bus.other_wdata_out  = bus.ahb_wdata_in;
endmodule

// File: tb/tb_ahb_slave_bridge.sv
// tb/tb_ahb_slave_bridge.sv - randomized self-checking bench for ahb_slave_bridge against a transfer-level model
module tb_ahb_slave_bridge;
  localparam int DW = 32;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ahb_slave_bridge_if #(.AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW)) bus ();

  ahb_slave_bridge #(.AHB_DATA_WIDTH(DW), .AHB_ADDR_WIDTH(AW), .AHB_WAIT_TIMEOUT(6)) dut (
    .ahb_clk_in(clk),
    .ahb_rst_in(rst),
    .bus(bus)
  );

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wdata;
    int          wait_c;
    bit          err;
    bit          legal;
    int          rst_k;
  } beat_t;

  beat_t beats[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int total_beats(input logic [2:0] b);
    case (b)
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      3'd6, 3'd7: return 16;
      default:    return 1;
    endcase
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] a, input logic [2:0] b, input logic [2:0] s);
    int unsigned step, len;
    logic [31:0] base;
    step = 32'd1 << s;
    if (b == 3'd2 || b == 3'd4 || b == 3'd6) begin
      len  = 32'(total_beats(b)) * step;
      base = a - (a % len);
      return base + ((a - base + step) % len);
    end
    return a + step;
  endfunction

  function automatic logic [3:0] model_strb(input logic [31:0] a, input logic [2:0] s);
    logic [3:0] r;
    int lo, hi;
    r  = 4'd0;
    lo = int'(a % 4);
    hi = lo + (1 << s);
    for (int b = 0; b < 4; b++) if (b >= lo && b < hi) r[b] = 1'b1;
    return r;
  endfunction

  task automatic push(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b, input logic [2:0] s,
                      input logic w, input int wt, input bit e);
    beat_t x;
    x.trans = t; x.addr = a; x.burst = b; x.size = s; x.write = w;
    x.wdata = $urandom; x.wait_c = wt; x.err = e; x.legal = 1'b0; x.rst_k = -1;
    beats.push_back(x);
  endtask

  // Walk the beat list in acceptance order and decide legality of each transfer
  task automatic classify();
    bit act, inf, ok, can;
    int rem;
    logic [31:0] pred;
    logic [2:0] b, s;
    logic w;
    act = 0; inf = 0; rem = 0; pred = 0; b = 0; s = 0; w = 0;
    for (int i = 0; i < beats.size(); i++) begin
      beats[i].legal = 1'b0;
      if (beats[i].trans == 2'd0) act = 0;
      if (beats[i].trans[1]) begin
        ok = ((8 << beats[i].size) <= DW) && ((beats[i].addr % (32'd1 << beats[i].size)) == 0);
        if (beats[i].trans == 2'd2) begin
          beats[i].legal = ok;
          act = ok;
          if (ok) begin
            b = beats[i].burst; s = beats[i].size; w = beats[i].write;
            inf = (b == 3'd1);
            rem = total_beats(b) - 1;
            pred = model_next(beats[i].addr, b, s);
          end
        end else begin
          can = act && (inf || rem > 0);
          beats[i].legal = ok && can && beats[i].addr == pred && beats[i].burst == b &&
                           beats[i].size == s && beats[i].write == w;
          if (can) begin
            if (!inf) rem--;
            pred = model_next(pred, b, s);
          end
        end
      end
    end
  endtask

  task automatic drive_idle();
    bus.ahb_sel_in = 1'b1; bus.ahb_addr_in = '0; bus.ahb_trans_in = 2'd0; bus.ahb_burst_in = 3'd0;
    bus.ahb_size_in = 3'd0; bus.ahb_write_in = 1'b0; bus.ahb_wdata_in = '0; bus.ahb_ready_in = 1'b1;
    bus.other_ready_in = 1'b0; bus.other_error_in = 1'b0; bus.other_rdata_in = '0;
  endtask

  task automatic check_reset_values(input string tag);
    @(negedge clk);
    check({tag, "_readyout"}, 64'(bus.ahb_readyout_out), 64'd1);
    check({tag, "_resp"},     64'(bus.ahb_resp_out), 64'd0);
    check({tag, "_rdata"},    64'(bus.ahb_rdata_out), 64'd0);
    check({tag, "_req"},      64'(bus.other_req_out), 64'd0);
    check({tag, "_addr"},     64'(bus.other_addr_out), 64'd0);
    check({tag, "_write"},    64'(bus.other_write_out), 64'd0);
    check({tag, "_size"},     64'(bus.other_size_out), 64'd0);
    check({tag, "_strb"},     64'(bus.other_strb_out), 64'd0);
  endtask

  // Pipelined AHB master plus backend responder; advances on the model's expected HREADYOUT
  task automatic run_beats();
    int ai, di, k, n;
    bit exp_rdy, exp_resp, exp_req, drv_rdy, drv_err, rst_now;
    logic [31:0] rdat;
    beat_t cur;
    classify();
    ai = 0; di = -1; k = 0; n = beats.size();
    forever begin
      exp_rdy = 1; exp_resp = 0; exp_req = 0; drv_rdy = 0; drv_err = 0; rst_now = 0;
      if (di >= 0) begin
        cur = beats[di];
        if (cur.trans[1]) begin
          if (!cur.legal) begin
            exp_resp = 1; exp_rdy = (k == 1);
          end else if (k < cur.wait_c) begin
            exp_rdy = 0; exp_req = 1; rst_now = (k == cur.rst_k);
          end else if (k == cur.wait_c) begin
            exp_req = 1;
            if (cur.err) begin drv_err = 1; exp_rdy = 0; end
            else drv_rdy = 1;
          end else begin
            exp_resp = 1; exp_rdy = (k == cur.wait_c + 2);
          end
        end
      end
      if (ai < n) begin
        bus.ahb_trans_in = beats[ai].trans; bus.ahb_addr_in = beats[ai].addr;
        bus.ahb_burst_in = beats[ai].burst; bus.ahb_size_in = beats[ai].size;
        bus.ahb_write_in = beats[ai].write;
      end else begin
        bus.ahb_trans_in = 2'd0; bus.ahb_addr_in = '0; bus.ahb_burst_in = 3'd0;
        bus.ahb_size_in = 3'd0; bus.ahb_write_in = 1'b0;
      end
      bus.ahb_sel_in = 1'b1;
      bus.ahb_wdata_in = (di >= 0) ? beats[di].wdata : '0;
      rdat = $urandom;
      bus.other_rdata_in = rdat; bus.other_ready_in = drv_rdy; bus.other_error_in = drv_err;
      bus.ahb_ready_in = exp_rdy;
      rst = rst_now;
      @(negedge clk);
      check("readyout", 64'(bus.ahb_readyout_out), 64'(exp_rdy));
      check("resp", 64'(bus.ahb_resp_out), 64'(exp_resp));
      check("req", 64'(bus.other_req_out), 64'(exp_req));
      check("rdata", 64'(bus.ahb_rdata_out), drv_rdy ? 64'(rdat) : 64'd0);
      if (exp_req) begin
        check("other_addr", 64'(bus.other_addr_out), 64'(cur.addr));
        check("other_write", 64'(bus.other_write_out), 64'(cur.write));
        check("other_size", 64'(bus.other_size_out), 64'(cur.size));
        check("other_strb", 64'(bus.other_strb_out), 64'(model_strb(cur.addr, cur.size)));
        check("other_wdata", 64'(bus.other_wdata_out), 64'(cur.wdata));
      end
      @(posedge clk); #1;
      if (rst_now) begin rst = 1'b0; break; end
      if (exp_rdy) begin
        if (ai >= n) break;
        di = ai; ai++; k = 0;
      end else k++;
    end
    drive_idle();
    beats.delete();
  endtask

  task automatic gen_group();
    logic [2:0] b, s;
    logic w;
    logic [31:0] a;
    int tot;
    b = 3'($urandom_range(0, 7));
    s = 3'($urandom_range(0, 2));
    if ($urandom_range(0, 15) == 0) s = 3'd3;
    tot = (b == 3'd1) ? int'($urandom_range(1, 6)) : total_beats(b);
    a = $urandom_range(0, 32'hFFF) & ~((32'd1 << s) - 32'd1);
    if (s != 3'd0 && $urandom_range(0, 15) == 0) a = a | 32'd1;
    w = 1'($urandom_range(0, 1));
    for (int j = 0; j < tot; j++) begin
      if (j > 0 && $urandom_range(0, 5) == 0) push(2'd1, a, b, s, w, 0, 0);
      if (j > 0 && $urandom_range(0, 19) == 0)
        push(2'd3, a ^ 32'h40, b, s, w, $urandom_range(0, 3), $urandom_range(0, 15) == 0);
      else
        push((j == 0) ? 2'd2 : 2'd3, a, b, s, w, $urandom_range(0, 3), $urandom_range(0, 15) == 0);
      a = model_next(a, b, s);
    end
    if (b != 3'd1 && $urandom_range(0, 7) == 0) push(2'd3, a, b, s, w, 0, 0);
    if ($urandom_range(0, 3) == 0) push(2'd0, 32'd0, 3'd0, 3'd0, 1'b0, 0, 0);
  endtask

  initial begin
    int cnt;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    push(2'd2, 32'h100, 3'd0, 3'd2, 1'b1, 0, 0);
    beats[0].wdata = 32'hA5A5_0001;
    run_beats();
    push(2'd2, 32'h104, 3'd0, 3'd2, 1'b0, 2, 0);
    run_beats();
    push(2'd2, 32'h38, 3'd2, 3'd2, 1'b1, 0, 0); push(2'd3, 32'h3C, 3'd2, 3'd2, 1'b1, 1, 0);
    push(2'd3, 32'h30, 3'd2, 3'd2, 1'b1, 0, 0); push(2'd3, 32'h34, 3'd2, 3'd2, 1'b1, 0, 0);
    run_beats();
    push(2'd2, 32'h38, 3'd2, 3'd2, 1'b1, 0, 0); push(2'd3, 32'h40, 3'd2, 3'd2, 1'b1, 0, 0);
    push(2'd3, 32'h30, 3'd2, 3'd2, 1'b1, 0, 0); push(2'd3, 32'h34, 3'd2, 3'd2, 1'b1, 0, 0);
    run_beats();
    push(2'd2, 32'h102, 3'd0, 3'd2, 1'b1, 0, 0);
    run_beats();

    // Backend that never answers
    bus.ahb_trans_in = 2'd2; bus.ahb_addr_in = 32'h300; bus.ahb_size_in = 3'd2; bus.ahb_ready_in = 1'b1;
    @(posedge clk); #1;
    drive_idle();
    bus.ahb_ready_in = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.other_req_out) cnt++;
      else break;
      @(posedge clk); #1;
    end
`ifdef AHB_TIMEOUT_EN
    check("timeout_cycles", 64'(cnt), 64'd6);
    check("timeout_err1_ready", 64'(bus.ahb_readyout_out), 64'd0);
    check("timeout_err1_resp", 64'(bus.ahb_resp_out), 64'd1);
    @(posedge clk); #1;
    bus.ahb_ready_in = 1'b1;
    @(negedge clk);
    check("timeout_err2_ready", 64'(bus.ahb_readyout_out), 64'd1);
    check("timeout_err2_resp", 64'(bus.ahb_resp_out), 64'd1);
    @(posedge clk); #1;
`else
    check("wait_cycles", 64'(cnt), 64'd20);
    check("wait_ready", 64'(bus.ahb_readyout_out), 64'd0);
    bus.other_ready_in = 1'b1; bus.ahb_ready_in = 1'b1;
    @(negedge clk);
    check("wait_done_ready", 64'(bus.ahb_readyout_out), 64'd1);
    check("wait_done_resp", 64'(bus.ahb_resp_out), 64'd0);
    @(posedge clk); #1;
`endif
    drive_idle();

    push(2'd2, 32'h200, 3'd5, 3'd2, 1'b1, 0, 0); push(2'd3, 32'h204, 3'd5, 3'd2, 1'b1, 1, 0);
    push(2'd3, 32'h208, 3'd5, 3'd2, 1'b1, 0, 0); push(2'd1, 32'h20C, 3'd5, 3'd2, 1'b1, 0, 0);
    push(2'd3, 32'h20C, 3'd5, 3'd2, 1'b1, 0, 0); push(2'd3, 32'h210, 3'd5, 3'd2, 1'b1, 4, 0);
    push(2'd3, 32'h214, 3'd5, 3'd2, 1'b1, 0, 0);
    beats[5].rst_k = 2;
    run_beats();
    check_reset_values("midreset");
    @(posedge clk); #1;
    push(2'd2, 32'h400, 3'd1, 3'd2, 1'b1, 1, 0); push(2'd3, 32'h404, 3'd1, 3'd2, 1'b1, 0, 0);
    run_beats();

    for (int g = 0; g < 30; g++) begin
      repeat (3) gen_group();
      run_beats();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
